if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the program counter and runs a request/response handshake with instruction memory. Presents `pc` and `instruction` to IF/ID and generates `im_stall` while the instruction for the current PC is unavailable. Applies trap and branch redirects, including redirects that arrive while a memory response is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `PC_write` in 1: hazard-unit enable, paired with IF/ID's `IFID_write`; 0 = hold PC.
- `dm_stall` in 1: data-memory stall; blocks PC advance.
- `CSR_stall` in 1: CSR stall; blocks PC advance.
- `branch_taken` in 1: redirect request from EX.
- `branch_target` in 32: EX redirect address.
- `trap_valid` in 1: CSR trap/mret redirect; has priority over `branch_taken`.
- `trap_target` in 32: CSR redirect address.
- `im_req` out 1: fetch request valid.
- `im_addr` out 32: fetch address, equal to `pc_q`.
- `im_ready` in 1: memory accepts the request this cycle.
- `im_rvalid` in 1: read data valid.
- `im_rdata` in 32: read data.
- `pc` out 32: address of the presented instruction, equal to `pc_q`.
- `instruction` out 32: fetched instruction; 32'h0 when not valid.
- `im_stall` out 1: 1 = `instruction` not valid this cycle.

## Operation
- Definitions:
  - `advance = PC_write & ~dm_stall & ~CSR_stall`.
  - `redir = trap_valid | branch_taken`.
  - `tgt = trap_valid ? trap_target : branch_target`, with bits [1:0] forced to 0.
- Registers: `state`, `pc_q`, `buf_q` (32), `kill_q` (1).
- States: RST, REQ, WAIT, HOLD.
- RST:
  - `im_req=0`. Next state is always REQ.
  - `redir` in RST loads `pc_q<=tgt`.
- REQ:
  - `im_req=1`, `im_addr=pc_q`.
  - `redir` loads `pc_q<=tgt`. If `im_ready` is also high that cycle, the old address was accepted: set `kill_q<=1`, go to WAIT.
  - `im_ready` without `redir` goes to WAIT.
  - Memory must sample `im_addr` only in the cycle `im_req & im_ready`. The address may change while not yet accepted.
- WAIT:
  - `im_req=0`.
  - `im_rvalid` with `kill_q` or `redir`: drop the data, clear `kill_q`, go to REQ. `redir` also loads `pc_q<=tgt`.
  - `im_rvalid`, no kill, no `redir`: `buf_q<=im_rdata`.
    - If `advance`: `pc_q<=pc_q+4` (mod 2^32), go to REQ.
    - Otherwise go to HOLD.
  - `redir` without `im_rvalid`: `pc_q<=tgt`, `kill_q<=1`, stay in WAIT.
- HOLD:
  - `im_req=0`.
  - `redir`: `pc_q<=tgt`, go to REQ.
  - Otherwise, if `advance`: `pc_q<=pc_q+4`, go to REQ.
- Outputs:
  - `instruction = im_rdata` in WAIT when `im_rvalid & ~kill_q`.
  - `instruction = buf_q` in HOLD.
  - `instruction = 32'h0` otherwise.
  - `im_stall` = 0 exactly when `instruction` is valid by the rule above, else 1.
  - `im_stall` and `instruction` do not depend on `redir`; no combinational path from EX. Squashing the wrong-path instruction in IF/ID is done by the hazard unit via `IFID_flush`.
- `im_rvalid` outside WAIT is ignored.
- PC increments wrap at 2^32 with no flag.

## Timing
- Reset values:
  - `state=RST`, `pc_q=RESET_PC`, `buf_q=0`, `kill_q=0`.
  - Outputs: `im_req=0`, `pc=RESET_PC`, `instruction=0`, `im_stall=1`.
- Reset mid-operation: any outstanding response is ignored after reset. Instruction memory resets on the same `reset`.
- First request: `im_req=1` in the 2nd cycle after reset deasserts.
- Zero-wait memory (`im_ready=1` in REQ, `im_rvalid` the next cycle):
  - Instruction valid in the WAIT cycle.
  - Steady-state throughput is 1 instruction per 2 cycles.
- Held instruction: while `advance=0`, `instruction` and `pc` remain stable in HOLD for any number of cycles.
- Simultaneous events:
  - `trap_valid` and `branch_taken` together: the trap target is used.
  - `redir` and `advance` together: `redir` wins.
  - `redir` and `im_ready` together in REQ: the accepted request is killed.
  - Multiple redirects during one WAIT: the last target wins; exactly one response is dropped.

## Test plan
- Reset release, `RESET_PC`=0, zero-wait memory returning 32'h00500093 → `im_req=1` in cycle 2, `instruction`=32'h00500093 with `im_stall=0` in cycle 3, next `im_addr`=32'h4.
- `dm_stall=1` for 5 cycles after data returns → HOLD, `instruction`/`pc` held 5 cycles, then `pc` becomes 32'h4 one cycle after the stall drops.
- `branch_taken=1`, `branch_target`=32'h103 while in WAIT, `im_rvalid` 3 cycles later → data dropped, `im_stall=1`, next request `im_addr`=32'h100.
- `trap_valid`=1 (32'h8000_0000) and `branch_taken`=1 (32'h200) in the same HOLD cycle → next `im_addr`=32'h8000_0000.
- `pc_q`=32'hFFFF_FFFC, advance → next `im_addr`=32'h0.
- `reset` asserted while in WAIT, `im_rvalid` arrives during reset → `pc=RESET_PC`, `instruction`=0, `im_stall`=1; no data captured.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC and runs a req/rsp handshake with instruction memory.
// Instruction is valid in the response cycle (or held in HOLD); im_stall flags every other cycle.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        dm_stall,
    input  logic        CSR_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        im_stall
);

    typedef enum logic [1:0] {RST, REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] buf_q, buf_n;
    logic        kill_q, kill_n;

    logic        advance;
    logic        redir;
    logic [31:0] tgt;

    assign advance = PC_write & ~dm_stall & ~CSR_stall;
    assign redir   = trap_valid | branch_taken;
    assign tgt     = (trap_valid ? trap_target : branch_target) & ~32'h3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RST;
            pc_q   <= RESET_PC;
            buf_q  <= 32'h0;
            kill_q <= 1'b0;
        end else begin
            state  <= state_n;
            pc_q   <= pc_n;
            buf_q  <= buf_n;
            kill_q <= kill_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        buf_n   = buf_q;
        kill_n  = kill_q;
        case (state)
            RST: begin
                state_n = REQ;
                if (redir) pc_n = tgt;
            end
            REQ: begin
                if (redir) pc_n = tgt;
                if (im_ready) begin
                    state_n = WAIT;
                    // The old address was already accepted; its response must be dropped.
                    if (redir) kill_n = 1'b1;
                end
            end
            WAIT: begin
                if (im_rvalid) begin
                    if (kill_q || redir) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                        if (redir) pc_n = tgt;
                    end else begin
                        buf_n = im_rdata;
                        if (advance) begin
                            pc_n    = pc_q + 32'd4;
                            state_n = REQ;
                        end else begin
                            state_n = HOLD;
                        end
                    end
                end else if (redir) begin
                    pc_n   = tgt;
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_n    = tgt;
                    state_n = REQ;
                end else if (advance) begin
                    pc_n    = pc_q + 32'd4;
                    state_n = REQ;
                end
            end
            default: state_n = RST;
        endcase
    end

    // Outputs depend only on registered state and the memory response, never on EX redirects.
    always_comb begin
        instruction = 32'h0;
        im_stall    = 1'b1;
        if (state == WAIT && im_rvalid && !kill_q) begin
            instruction = im_rdata;
            im_stall    = 1'b0;
        end else if (state == HOLD) begin
            instruction = buf_q;
            im_stall    = 1'b0;
        end
    end

    assign im_req  = (state == REQ);
    assign im_addr = pc_q;
    assign pc      = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a transaction-level fetch model plus a latency-randomized memory.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, PC_write, dm_stall, CSR_stall, branch_taken, trap_valid;
    logic [31:0] branch_target, trap_target;
    logic        im_req, im_ready, im_rvalid;
    logic [31:0] im_addr, im_rdata, pc, instruction;
    logic        im_stall;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .PC_write(PC_write), .dm_stall(dm_stall),
        .CSR_stall(CSR_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .trap_valid(trap_valid), .trap_target(trap_target), .im_req(im_req),
        .im_addr(im_addr), .im_ready(im_ready), .im_rvalid(im_rvalid),
        .im_rdata(im_rdata), .pc(pc), .instruction(instruction), .im_stall(im_stall)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: is the unit started, waiting on a fetch (possibly stale), or holding one.
    bit          m_started, m_fetching, m_stale, m_have;
    logic [31:0] m_pc, m_held;

    // Memory side
    bit          mem_busy;
    int          mem_cnt;
    int          max_lat;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_started = 0; m_fetching = 0; m_stale = 0; m_have = 0;
        m_pc = RST_PC; m_held = 32'h0;
    endtask

    // One clock cycle: inputs are already driven; drive memory, check outputs, advance models.
    task automatic cycle(input bit chk);
        logic [31:0] exp_instr, t;
        bit          valid, adv, rd;
        if (mem_busy && mem_cnt == 0) begin
            im_rvalid = 1'b1;
            im_rdata  = mem_word(mem_addr);
        end else begin
            im_rvalid = !mem_busy && ($urandom_range(9) == 0);
            im_rdata  = $urandom;
        end
        #1;
        valid     = (m_fetching && im_rvalid && !m_stale) || m_have;
        exp_instr = m_have ? m_held : (valid ? im_rdata : 32'h0);
        if (chk) begin
            check("im_req", {31'h0, im_req}, {31'h0, m_started && !m_fetching && !m_have});
            check("im_addr", im_addr, m_pc);
            check("pc", pc, m_pc);
            check("instruction", instruction, exp_instr);
            check("im_stall", {31'h0, im_stall}, {31'h0, !valid});
        end
        adv = PC_write && !dm_stall && !CSR_stall;
        rd  = trap_valid || branch_taken;
        t   = trap_valid ? trap_target : branch_target;
        t[1:0] = 2'b00;
        if (!reset) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
            if (rd) m_pc = t;
        end else if (m_have) begin
            if (rd) begin m_pc = t; m_have = 0; end
            else if (adv) begin m_pc = m_pc + 32'd4; m_have = 0; end
        end else if (m_fetching) begin
            if (im_rvalid) begin
                m_fetching = 0;
                if (m_stale || rd) begin
                    m_stale = 0;
                    if (rd) m_pc = t;
                end else if (adv) m_pc = m_pc + 32'd4;
                else begin m_held = im_rdata; m_have = 1; end
            end else if (rd) begin
                m_pc = t; m_stale = 1;
            end
        end else begin
            if (rd) m_pc = t;
            if (im_ready) begin m_fetching = 1; m_stale = rd; end
        end
        if (!reset) mem_busy = 0;
        else begin
            if (mem_busy) begin
                if (mem_cnt == 0) mem_busy = 0;
                else mem_cnt--;
            end
            if (im_req && im_ready) begin
                mem_busy = 1; mem_addr = im_addr; mem_cnt = $urandom_range(max_lat);
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0: return 32'hFFFF_FFFC;
            1: return 32'h0000_0103;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic quiet_inputs();
        PC_write = 1; dm_stall = 0; CSR_stall = 0;
        branch_taken = 0; trap_valid = 0;
        branch_target = 32'h0; trap_target = 32'h0; im_ready = 1;
    endtask

    initial begin
        reset = 0; quiet_inputs(); im_rvalid = 0; im_rdata = 0;
        mem_busy = 0; mem_cnt = 0; max_lat = 0; mem_addr = 0;
        model_reset();

        @(negedge clk); cycle(0);
        @(negedge clk); cycle(1);
        check("rst_im_stall", {31'h0, im_stall}, 32'h1);

        // Reset release with zero-wait memory
        @(negedge clk); reset = 1; cycle(1);
        check("c1_im_req", {31'h0, im_req}, 32'h0);
        @(negedge clk); cycle(1);
        check("c2_im_req", {31'h0, im_req}, 32'h1);
        @(negedge clk); dm_stall = 1; cycle(1);
        check("c3_instr", instruction, 32'h0050_0093);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cycle(1);
            check("hold_instr", instruction, 32'h0050_0093);
            check("hold_pc", pc, 32'h0);
        end
        @(negedge clk); dm_stall = 0; cycle(1);
        @(negedge clk); cycle(1);
        check("adv_addr", im_addr, 32'h4);

        // Randomized phase
        max_lat = 3;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            reset         = ($urandom_range(299) != 0);
            PC_write      = ($urandom_range(9) < 8);
            dm_stall      = ($urandom_range(9) < 2);
            CSR_stall     = ($urandom_range(9) == 0);
            branch_taken  = ($urandom_range(11) == 0);
            trap_valid    = ($urandom_range(24) == 0);
            branch_target = pick_target();
            trap_target   = pick_target();
            im_ready      = ($urandom_range(9) < 6);
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
